// File: rtl/hex_word_entry.sv
// Operator word entry: builds a word nibble-by-nibble from the switches
// and hands it to the CPU over a request/acknowledge read handshake.
module hex_word_entry #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH/4)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_load,
  input  logic             btn_back,
  input  logic             btn_commit,
  input  logic             btn_clear,
  input  logic [3:0]       sw_val,
  input  logic             rd_req,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             rd_ack,
  output logic [WIDTH-1:0] edit_word,
  output logic [CW-1:0]    cursor,
  output logic [1:0]       state,
  output logic             overrun
);

  localparam int NIB = WIDTH/4;

  logic [3:0]       btn;
  logic [3:0]       ev;
  logic             do_clr;
  logic             do_cmt;
  logic             do_ld;
  logic             do_bk;
  logic             rd;
  logic             held_nx;
  logic [CW-1:0]    cur_inc;
  logic [CW-1:0]    cur_dec;

  logic [3:0]       prev_q,    prev_d;
  logic [WIDTH-1:0] word_q,    word_d;
  logic             valid_q,   valid_d;
  logic             ack_q,     ack_d;
  logic [WIDTH-1:0] edit_q,    edit_d;
  logic [CW-1:0]    cursor_q,  cursor_d;
  logic             dirty_q,   dirty_d;
  logic             overrun_q, overrun_d;

  assign btn = {btn_clear, btn_commit, btn_load, btn_back};
  assign ev  = btn & ~prev_q;

  // Only the highest-priority event acts; the rest are dropped.
  assign do_clr = ev[3];
  assign do_cmt = ev[2] & ~ev[3];
  assign do_ld  = ev[1] & ~|ev[3:2];
  assign do_bk  = ev[0] & ~|ev[3:1];

  assign rd      = rd_req & valid_q;
  assign held_nx = valid_q & ~rd;

  assign cur_inc = (cursor_q == CW'(NIB-1)) ? '0 : cursor_q + CW'(1);
  assign cur_dec = (cursor_q == '0) ? CW'(NIB-1) : cursor_q - CW'(1);

  always_comb begin
    prev_d    = btn;
    word_d    = word_q;
    valid_d   = held_nx;
    ack_d     = rd;
    edit_d    = edit_q;
    cursor_d  = cursor_q;
    dirty_d   = dirty_q;
    overrun_d = overrun_q;
    unique case (1'b1)
      do_clr: begin
        edit_d    = '0;
        cursor_d  = '0;
        overrun_d = 1'b0;
        dirty_d   = 1'b0;
      end
      do_cmt: begin
        if (dirty_q && !held_nx) begin
          word_d   = edit_q;
          valid_d  = 1'b1;
          edit_d   = '0;
          cursor_d = '0;
          dirty_d  = 1'b0;
        end else if (dirty_q) begin
          overrun_d = 1'b1;
        end
      end
      do_ld: begin
        for (int i = 0; i < NIB; i++) begin
          if (cursor_q == CW'(i)) begin
            edit_d[4*(NIB-1-i) +: 4] = sw_val;
          end
        end
        cursor_d = cur_inc;
        dirty_d  = 1'b1;
      end
      do_bk: cursor_d = cur_dec;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '1;
      word_q    <= '0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      edit_q    <= '0;
      cursor_q  <= '0;
      dirty_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      edit_q    <= edit_d;
      cursor_q  <= cursor_d;
      dirty_q   <= dirty_d;
      overrun_q <= overrun_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign rd_ack     = ack_q;
  assign edit_word  = edit_q;
  assign cursor     = cursor_q;
  assign state      = {valid_q, dirty_q};
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_hex_word_entry.sv
// Bench for hex_word_entry: directed scenarios plus random
// button/read traffic against a nibble-array reference model.
module tb_hex_word_entry;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH/4;
  localparam int CW    = $clog2(NIB);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             btn_load = 1'b0;
  logic             btn_back = 1'b0;
  logic             btn_commit = 1'b0;
  logic             btn_clear = 1'b0;
  logic [3:0]       sw_val = 4'h0;
  logic             rd_req = 1'b0;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             rd_ack;
  logic [WIDTH-1:0] edit_word;
  logic [CW-1:0]    cursor;
  logic [1:0]       state;
  logic             overrun;

  hex_word_entry #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .btn_load(btn_load), .btn_back(btn_back),
    .btn_commit(btn_commit), .btn_clear(btn_clear),
    .sw_val(sw_val), .rd_req(rd_req),
    .word_out(word_out), .word_valid(word_valid),
    .rd_ack(rd_ack), .edit_word(edit_word),
    .cursor(cursor), .state(state), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_nib[NIB];
  int         m_cur;
  bit         m_dirty;
  bit         m_valid;
  bit         m_ack;
  bit         m_over;
  bit [31:0]  m_word;
  bit [3:0]   m_prev;

  function automatic bit [31:0] m_pack();
    bit [31:0] w = 0;
    for (int i = 0; i < NIB; i++) w = (w << 4) | 32'(m_nib[i]);
    return w;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit [3:0] lv;
    bit ec, em, el, eb, rd;
    lv = {btn_clear, btn_commit, btn_load, btn_back};
    if (reset) begin
      foreach (m_nib[i]) m_nib[i] = 0;
      m_cur = 0; m_dirty = 0; m_valid = 0;
      m_ack = 0; m_over = 0; m_word = 0;
      m_prev = 4'hF;
      return;
    end
    ec = lv[3] && !m_prev[3];
    em = lv[2] && !m_prev[2];
    el = lv[1] && !m_prev[1];
    eb = lv[0] && !m_prev[0];
    m_prev = lv;
    rd = rd_req && m_valid;
    m_ack = rd;
    if (rd) m_valid = 0;
    if (ec) begin
      foreach (m_nib[i]) m_nib[i] = 0;
      m_cur = 0; m_over = 0; m_dirty = 0;
    end else if (em) begin
      if (m_dirty && !m_valid) begin
        m_word = m_pack();
        m_valid = 1;
        foreach (m_nib[i]) m_nib[i] = 0;
        m_cur = 0; m_dirty = 0;
      end else if (m_dirty) begin
        m_over = 1;
      end
    end else if (el) begin
      m_nib[m_cur] = int'(sw_val);
      m_cur = (m_cur + 1) % NIB;
      m_dirty = 1;
    end else if (eb) begin
      m_cur = (m_cur + NIB - 1) % NIB;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("word_out", word_out, m_word);
    check("word_valid", 32'(word_valid), 32'(m_valid));
    check("rd_ack", 32'(rd_ack), 32'(m_ack));
    check("edit_word", edit_word, m_pack());
    check("cursor", 32'(cursor), 32'(m_cur));
    check("state", 32'(state), {30'd0, m_valid, m_dirty});
    check("overrun", 32'(overrun), 32'(m_over));
  endtask

  task automatic press_load(input logic [3:0] v);
    sw_val = v; btn_load = 1'b1; step();
    btn_load = 1'b0; step();
  endtask

  task automatic press_back();
    btn_back = 1'b1; step();
    btn_back = 1'b0; step();
  endtask

  task automatic press_commit();
    btn_commit = 1'b1; step();
    btn_commit = 1'b0; step();
  endtask

  task automatic press_clear();
    btn_clear = 1'b1; step();
    btn_clear = 1'b0; step();
  endtask

  initial begin
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 1; i <= 8; i++) press_load(4'(i));
    check("seq_edit", edit_word, 32'h12345678);
    check("seq_cursor", 32'(cursor), 32'd0);
    check("seq_state", 32'(state), 32'd1);
    press_commit();
    check("cmt_word", word_out, 32'h12345678);
    check("cmt_state", 32'(state), 32'd2);

    rd_req = 1'b1; step();
    check("rd_ack_pulse", 32'(rd_ack), 32'd1);
    rd_req = 1'b0; step();
    check("rd_state", 32'(state), 32'd0);
    check("rd_word_kept", word_out, 32'h12345678);
    rd_req = 1'b1;
    repeat (10) step();
    rd_req = 1'b0;

    press_back();
    check("wrap_back", 32'(cursor), 32'd7);
    press_load(4'hA);
    check("wrap_edit", edit_word, 32'h0000000A);

    press_clear();
    press_back(); press_back();
    press_load(4'hA); press_load(4'hB);
    press_commit();
    check("ovr_word", word_out, 32'h000000AB);
    press_load(4'hC);
    press_commit();
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_state", 32'(state), 32'd3);
    rd_req = 1'b1; btn_commit = 1'b1; step();
    check("rdcmt_ack", 32'(rd_ack), 32'd1);
    check("rdcmt_word", word_out, 32'hC0000000);
    check("rdcmt_state", 32'(state), 32'd2);
    rd_req = 1'b0; btn_commit = 1'b0; step();
    press_clear();
    check("clr_ovr", 32'(overrun), 32'd0);

    press_load(4'h5);
    sw_val = 4'h9; btn_clear = 1'b1; btn_load = 1'b1; step();
    check("clrld_edit", edit_word, 32'd0);
    btn_clear = 1'b0; btn_load = 1'b0; step();

    btn_load = 1'b1; reset = 1'b1; step();
    reset = 1'b0; sw_val = 4'h7; step(); step();
    btn_load = 1'b0; step();
    press_load(4'h7);
    check("hold_rst", edit_word, 32'h70000000);

    press_commit();
    rd_req = 1'b1; reset = 1'b1; step();
    check("rst_hs_valid", 32'(word_valid), 32'd0);
    check("rst_hs_ack", 32'(rd_ack), 32'd0);
    rd_req = 1'b0; reset = 1'b0; step();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) btn_load = ~btn_load;
      if ($urandom_range(0, 5) == 0) btn_back = ~btn_back;
      if ($urandom_range(0, 7) == 0) btn_commit = ~btn_commit;
      if ($urandom_range(0, 15) == 0) btn_clear = ~btn_clear;
      sw_val = 4'($urandom);
      rd_req = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
